// File: rtl/jtopll_wrq.sv
// jtopll_wrq: buffered, hardware-paced register-write scheduler for one or
// more jt2413-class OPLL chips. CPU writes are queued as {chip,addr,data} and
// replayed with a one-cen-tick strobe, spaced by the chip's address/data
// recovery time.
// Optional build macro: JTOPLL_WRQ_DBG_EN adds dbg_ovf / dbg_cnt ports.
module jtopll_wrq #(
  parameter int DEPTH     = 8,
  parameter int CHIPS     = 2,
  parameter int CSW       = 1,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic [7:0]             din,
  input  logic                   addr,
  input  logic [CSW-1:0]         chip,
  input  logic                   wr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             dout,
  output logic                   aout,
  output logic [CHIPS-1:0]       cs_n,
`ifdef JTOPLL_WRQ_DBG_EN
  output logic                   dbg_ovf,
  output logic [15:0]            dbg_cnt,
`endif
  output logic                   wr_n
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int EW   = CSW + 9;
  localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, STROBE, WAIT} state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [EW-1:0]    cur_reg;
  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             take, strobe_on, strobe_off;
  logic             push, pop, fifo_ne, cur_valid;
  logic [CSW-1:0]   cur_chip;
  logic [CHIPS-1:0] cs_sel;

  assign fifo_ne   = (level_reg != '0);
  assign full      = (level_reg == LW'(DEPTH));
  assign empty     = !fifo_ne && (state_reg == IDLE);
  assign level     = level_reg;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts it.
  assign push      = wr && (!full || pop);
  assign pop       = take && fifo_ne;
  assign cur_chip  = cur_reg[EW-1:9];
  assign cur_valid = (int'(cur_chip) < CHIPS);

  // Active-low select pattern for the chip held in the head register.
  genvar gi;
  generate
    for (gi = 0; gi < CHIPS; gi++) begin : g_cs
      assign cs_sel[gi] = (cur_chip != CSW'(gi));
    end
  endgenerate

  // Queue storage, written without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {chip, addr, din};
  end

  // Registered read of the FIFO head into the entry being issued.
  always_ff @(posedge clk) begin
    if (rst)      cur_reg <= '0;
    else if (pop) cur_reg <= mem[rd_ptr_reg];
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2**AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // FSM state and spacing counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic. "take" marks a tick on which the scheduler may pop the
  // next entry; the final wait tick doubles as that pop so strobes land
  // exactly ADDR_WAIT/DATA_WAIT ticks apart.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    take       = 1'b0;
    strobe_on  = 1'b0;
    strobe_off = 1'b0;
    if (cen) begin
      case (state_reg)
        IDLE: take = 1'b1;
        ISSUE: begin
          if (cur_valid) begin
            strobe_on  = 1'b1;
            cnt_next   = cur_reg[8] ? CW'(DATA_WAIT - 1) : CW'(ADDR_WAIT - 1);
            state_next = STROBE;
          end else begin
            // Unknown chip: drop silently and move straight on.
            take = 1'b1;
          end
        end
        STROBE: begin
          strobe_off = 1'b1;
          cnt_next   = cnt_reg - 1'b1;
          state_next = WAIT;
          if (cnt_reg == CW'(1)) take = 1'b1;
        end
        WAIT: begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) take = 1'b1;
        end
        default: state_next = IDLE;
      endcase
      if (take) state_next = fifo_ne ? ISSUE : IDLE;
    end
  end

  // Registered chip-side bus; dout/aout hold their last value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 8'h00;
      aout <= 1'b0;
      wr_n <= 1'b1;
      cs_n <= '1;
    end else if (strobe_on) begin
      dout <= cur_reg[7:0];
      aout <= cur_reg[8];
      wr_n <= 1'b0;
      cs_n <= cs_sel;
    end else if (strobe_off) begin
      wr_n <= 1'b1;
      cs_n <= '1;
    end
  end

`ifdef JTOPLL_WRQ_DBG_EN
  // Sticky overflow flag and wrapping count of issued strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_ovf <= 1'b0;
      dbg_cnt <= 16'h0000;
    end else begin
      if (wr && !push) dbg_ovf <= 1'b1;
      if (strobe_on)   dbg_cnt <= dbg_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtopll_wrq.sv
// Testbench for jtopll_wrq: scoreboard of expected strobes (pushed when the
// CPU write is driven) against strobes captured from the chip-side bus.
module tb_jtopll_wrq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic [7:0] din = 8'h00;
  logic       addr = 1'b0;
  logic [1:0] chip = 2'd0;
  logic       wr = 1'b0;
  logic       full, empty, aout, wr_n;
  logic [3:0] level;
  logic [7:0] dout;
  logic [1:0] cs_n;
`ifdef JTOPLL_WRQ_DBG_EN
  logic        dbg_ovf;
  logic [15:0] dbg_cnt;
`endif

  jtopll_wrq #(.DEPTH(8), .CHIPS(2), .CSW(2), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .chip(chip),
    .wr(wr), .full(full), .empty(empty), .level(level), .dout(dout),
    .aout(aout), .cs_n(cs_n),
`ifdef JTOPLL_WRQ_DBG_EN
    .dbg_ovf(dbg_ovf), .dbg_cnt(dbg_cnt),
`endif
    .wr_n(wr_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] vec;   // {cs_n, dout, aout}
    int          tick;
    int          cyc;
    int          len;
  } obs_t;

  int          checks = 0;
  int          errors = 0;
  int          tick = 0;
  int          cyc = 0;
  int          cen_div = 1;
  bit          cen_en = 1'b1;
  int          phase = 0;
  int          bad_cs = 0;
  int          last_push_tick = 0;
  logic [10:0] exp_q[$];
  obs_t        obs_q[$];
  obs_t        got[16];
  int          ngot;

  // cen generator: one pulse every cen_div clocks while enabled.
  always @(negedge clk) begin
    if (phase >= cen_div - 1) phase = 0;
    else phase = phase + 1;
    cen = cen_en && (phase == 0);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cen) tick <= tick + 1;
  end

  // Bus monitor: captures each strobe, flags any illegal chip-select pattern.
  bit   in_strobe = 1'b0;
  obs_t cur_o;
  always @(negedge clk) begin
    if (!wr_n) begin
      if (!in_strobe) begin
        in_strobe  = 1'b1;
        cur_o.vec  = {cs_n, dout, aout};
        cur_o.tick = tick;
        cur_o.cyc  = cyc;
        cur_o.len  = 0;
      end
      cur_o.len = cur_o.len + 1;
      if ($countones(~cs_n) != 1 || cs_n != cur_o.vec[10:9]) bad_cs = bad_cs + 1;
    end else begin
      if (cs_n != 2'b11) bad_cs = bad_cs + 1;
      if (in_strobe) begin
        in_strobe = 1'b0;
        obs_q.push_back(cur_o);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    exp_q.delete();
    obs_q.delete();
    bad_cs = 0;
  endtask

  // Drive one push cycle; caller is positioned just after a negedge.
  task automatic push_wr(input logic [1:0] c, input logic a, input logic [7:0] d,
                         input bit expect_strobe);
    chip = c;
    addr = a;
    din  = d;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
    last_push_tick = tick;
    if (expect_strobe) exp_q.push_back({(c == 2'd0) ? 2'b10 : 2'b01, d, a});
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    int k = 0;
    while (empty !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    ok = (empty === 1'b1);
  endtask

  task automatic collect(input int n);
    ngot = 0;
    while (ngot < n && obs_q.size() > 0) begin
      got[ngot] = obs_q.pop_front();
      ngot++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cs_n, wr_n, dout, aout} !== {2'b11, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_bus: got cs_n=%b wr_n=%b dout=%h aout=%b, want 11/1/00/0", cs_n, wr_n, dout, aout);
    end
    checks++;
    if ({full, empty, level} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_fifo: got full=%b empty=%b level=%0d, want 0/1/0", full, empty, level);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit ok;
    logic [10:0] e;
    do_reset();
    push_wr(2'd0, 1'b0, 8'h10, 1'b1);
    push_wr(2'd0, 1'b1, 8'h25, 1'b1);
    wait_obs(2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d strobes, want 2", obs_q.size()); end
    collect(2);
    for (int i = 0; i < ngot; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[i].vec !== e || got[i].len != 1) begin
        errors++;
        $display("FAIL basic_strobe%0d: got vec=%h len=%0d, want vec=%h len=1", i, got[i].vec, got[i].len, e);
      end
      $display("basic strobe %0d vec=%h tick=%0d", i, got[i].vec, got[i].tick);
    end
    if (ngot == 2) begin
      checks++;
      if (got[1].tick - got[0].tick != 12) begin
        errors++;
        $display("FAIL basic_spacing: got %0d ticks, want 12", got[1].tick - got[0].tick);
      end
      wait_empty(300, ok);
      checks++;
      if (!ok || tick - got[1].tick < 83 || tick - got[1].tick > 84) begin
        errors++;
        $display("FAIL basic_empty: got empty=%b after %0d ticks, want 1 after 83..84", empty, tick - got[1].tick);
      end
    end
  endtask

  task automatic test_cen4();
    bit ok;
    int k = 0;
    logic [10:0] e;
    do_reset();
    cen_div = 4;
    while (cen !== 1'b1 && k < 8) begin step(); k++; end
    push_wr(2'd0, 1'b0, 8'h01, 1'b1);
    push_wr(2'd0, 1'b1, 8'h30, 1'b1);
    push_wr(2'd1, 1'b0, 8'h02, 1'b1);
    checks++;
    if (level !== 4'd3) begin errors++; $display("FAIL cen4_level: got %0d, want 3", level); end
    wait_obs(3, 1200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cen4_timeout: got %0d strobes, want 3", obs_q.size()); end
    collect(3);
    for (int i = 0; i < ngot; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[i].vec !== e || got[i].len != 4) begin
        errors++;
        $display("FAIL cen4_strobe%0d: got vec=%h len=%0d, want vec=%h len=4", i, got[i].vec, got[i].len, e);
      end
      $display("cen4 strobe %0d vec=%h tick=%0d cyc=%0d", i, got[i].vec, got[i].tick, got[i].cyc);
    end
    if (ngot == 3) begin
      checks++;
      if (got[1].tick - got[0].tick != 12 || got[2].tick - got[1].tick != 84 ||
          got[1].cyc - got[0].cyc != 48 || got[2].cyc - got[1].cyc != 336) begin
        errors++;
        $display("FAIL cen4_spacing: got %0d/%0d ticks %0d/%0d clk, want 12/84 ticks 48/336 clk",
                 got[1].tick - got[0].tick, got[2].tick - got[1].tick,
                 got[1].cyc - got[0].cyc, got[2].cyc - got[1].cyc);
      end
    end
    wait_empty(1500, ok);
    checks++;
    if (!ok || level !== 4'd0) begin errors++; $display("FAIL cen4_drain: got empty=%b level=%0d, want 1/0", empty, level); end
    cen_div = 1;
  endtask

  task automatic test_full();
    bit ok;
    logic [10:0] e;
    do_reset();
    cen_en = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      push_wr(2'(i % 2), 1'b0, 8'h80 + 8'(i), i < 8);
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || level !== 4'd8) begin
          errors++;
          $display("FAIL full_at8: got full=%b level=%0d, want 1/8", full, level);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL full_drop: got full=%b level=%0d strobes=%0d, want 1/8/0", full, level, obs_q.size());
    end
`ifdef JTOPLL_WRQ_DBG_EN
    checks++;
    if (dbg_ovf !== 1'b1) begin errors++; $display("FAIL dbg_ovf: got %b, want 1", dbg_ovf); end
`endif
    cen_en = 1'b1;
    wait_obs(8, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: got %0d strobes, want 8", obs_q.size()); end
    collect(8);
    for (int i = 0; i < ngot; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[i].vec !== e) begin
        errors++;
        $display("FAIL full_order%0d: got %h, want %h", i, got[i].vec, e);
      end
      $display("full strobe %0d vec=%h", i, got[i].vec);
    end
    repeat (40) step();
    checks++;
    if (obs_q.size() != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_extra: got %0d extra strobes empty=%b, want 0/1", obs_q.size(), empty);
    end
`ifdef JTOPLL_WRQ_DBG_EN
    checks++;
    if (dbg_cnt !== 16'd8) begin errors++; $display("FAIL dbg_cnt: got %0d, want 8", dbg_cnt); end
`endif
  endtask

  task automatic test_two_chips();
    bit ok;
    logic [10:0] e;
    do_reset();
    push_wr(2'd1, 1'b1, 8'h5A, 1'b1);
    push_wr(2'd0, 1'b1, 8'hA5, 1'b1);
    wait_obs(2, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL chips_timeout: got %0d strobes, want 2", obs_q.size()); end
    collect(2);
    for (int i = 0; i < ngot; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got[i].vec !== e) begin
        errors++;
        $display("FAIL chips_strobe%0d: got %h, want %h", i, got[i].vec, e);
      end
      $display("chips strobe %0d cs_n=%b dout=%h", i, got[i].vec[10:9], got[i].vec[8:1]);
    end
    if (ngot == 2) begin
      checks++;
      if (got[1].tick - got[0].tick != 84) begin
        errors++;
        $display("FAIL chips_spacing: got %0d ticks, want 84", got[1].tick - got[0].tick);
      end
    end
    checks++;
    if (bad_cs != 0) begin errors++; $display("FAIL chips_cs_glitch: got %0d bad samples, want 0", bad_cs); end
  endtask

  task automatic test_bad_chip();
    bit ok;
    int t0;
    logic [10:0] e;
    do_reset();
    push_wr(2'd3, 1'b0, 8'h77, 1'b0);
    t0 = last_push_tick;
    push_wr(2'd0, 1'b0, 8'h33, 1'b1);
    wait_obs(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL badchip_timeout: got %0d strobes, want 1", obs_q.size()); end
    collect(1);
    if (ngot == 1) begin
      e = exp_q.pop_front();
      checks++;
      if (got[0].vec !== e || got[0].tick - t0 != 3) begin
        errors++;
        $display("FAIL badchip_strobe: got vec=%h at +%0d ticks, want vec=%h at +3", got[0].vec, got[0].tick - t0, e);
      end
      $display("badchip strobe vec=%h tick_offset=%0d", got[0].vec, got[0].tick - t0);
    end
    repeat (30) step();
    checks++;
    if (obs_q.size() != 0 || bad_cs != 0) begin
      errors++;
      $display("FAIL badchip_extra: got %0d strobes %0d bad cs, want 0/0", obs_q.size(), bad_cs);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t0;
    logic [10:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) push_wr(2'd0, 1'b1, 8'h60 + 8'(i), 1'b1);
    wait_obs(1, 50, ok);
    checks++;
    if (!ok || level !== 4'd4) begin
      errors++;
      $display("FAIL rstmid_pre: got %0d strobes level=%0d, want 1/4", obs_q.size(), level);
    end
    collect(1);
    if (ngot == 1) begin
      e = exp_q.pop_front();
      checks++;
      if (got[0].vec !== e) begin errors++; $display("FAIL rstmid_first: got %h, want %h", got[0].vec, e); end
    end
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({cs_n, wr_n, level, empty} !== {2'b11, 1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_state: got cs_n=%b wr_n=%b level=%0d empty=%b, want 11/1/0/1", cs_n, wr_n, level, empty);
    end
    push_wr(2'd1, 1'b0, 8'h44, 1'b1);
    t0 = last_push_tick;
    wait_obs(1, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_timeout: got %0d strobes, want 1", obs_q.size()); end
    collect(1);
    if (ngot == 1) begin
      e = exp_q.pop_front();
      checks++;
      if (got[0].vec !== e || got[0].tick - t0 != 2) begin
        errors++;
        $display("FAIL rstmid_new: got vec=%h at +%0d ticks, want vec=%h at +2", got[0].vec, got[0].tick - t0, e);
      end
      $display("rstmid strobe vec=%h tick_offset=%0d", got[0].vec, got[0].tick - t0);
    end
    repeat (100) step();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_discard: got %0d stale strobes, want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cen4();
    test_full();
    test_two_chips();
    test_bad_chip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
